// File: rtl/sobel_engine.sv
// Sobel edge engine: one start walks the source ROM and writes |Gx|+|Gy| (sat 8b) per pixel, border = 0.
// Latency: writes trail the last read of column x+1 by 3 cycles; interior writes 4 cycles apart.
// Backpressure: none; ROM data must arrive exactly 1 cycle after the address, RAM must accept every write.
module sobel_engine #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [7:0]        src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [7:0]        dst_data,
  output logic              dst_we,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] W_A        = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] X_LAST     = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] X_INT_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] Y_INT_LAST = ADDR_W'(IMG_H - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_ZTOP, S_PRELOAD, S_COLUMN, S_REDGE, S_ZBOT, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;   // y * IMG_W, kept incrementally
  logic [2:0]        ph_q, ph_d;               // sub-step inside PRELOAD / COLUMN
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [7:0]        dst_data_q, dst_data_d;
  logic              dst_we_q, dst_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Read request for this cycle: which window row, which column, and whether it completes an interior pixel.
  logic              iss_vld, iss_emit;
  logic [1:0]        iss_row;
  logic [ADDR_W-1:0] iss_col, iss_base, iss_waddr;

  // Read tags follow the ROM latency: s1 = address on the bus, s2 = data on src_data.
  logic              s1_vld_q, s1_emit_q, s2_vld_q, s2_emit_q;
  logic [1:0]        s1_row_q, s2_row_q;
  logic [ADDR_W-1:0] s1_waddr_q, s2_waddr_q;
  logic              cmp_vld_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic              pipe_busy;

  // p_q[r][c]: r=0 row above, c=0 left column. nc_q holds the top two pixels of the incoming column.
  logic [7:0]        p_q [3][3];
  logic [7:0]        nc_q [2];

  logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg, gx_abs, gy_abs;
  logic signed [10:0] gx, gy;
  logic [11:0]        mag;
  logic [7:0]         pix_sat;

  assign iss_waddr = row_base_q + x_q;
  assign pipe_busy = s1_vld_q | s2_vld_q | cmp_vld_q;
  assign busy_d    = (state_d != S_IDLE);
  assign src_addr_d = iss_vld ? (iss_base + iss_col) : src_addr_q;

  // Row base of the requested window row (row above, current row, row below).
  always_comb begin
    unique case (iss_row)
      2'd0:    iss_base = row_base_q - W_A;
      2'd1:    iss_base = row_base_q;
      default: iss_base = row_base_q + W_A;
    endcase
  end

  // Sobel kernels on the registered window, magnitude saturated to 8 bits.
  always_comb begin
    gx_pos  = 11'(p_q[0][2]) + {2'b00, p_q[1][2], 1'b0} + 11'(p_q[2][2]);
    gx_neg  = 11'(p_q[0][0]) + {2'b00, p_q[1][0], 1'b0} + 11'(p_q[2][0]);
    gy_pos  = 11'(p_q[2][0]) + {2'b00, p_q[2][1], 1'b0} + 11'(p_q[2][2]);
    gy_neg  = 11'(p_q[0][0]) + {2'b00, p_q[0][1], 1'b0} + 11'(p_q[0][2]);
    gx      = $signed(gx_pos - gx_neg);
    gy      = $signed(gy_pos - gy_neg);
    gx_abs  = gx[10] ? 11'(-gx) : 11'(gx);
    gy_abs  = gy[10] ? 11'(-gy) : 11'(gy);
    mag     = {1'b0, gx_abs} + {1'b0, gy_abs};
    pix_sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
  end

  // Frame walker: border writes and read scheduling; interior results override from the compute stage.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    ph_d       = ph_q;
    dst_we_d   = 1'b0;
    dst_addr_d = '0;
    dst_data_d = '0;
    done_d     = 1'b0;
    iss_vld    = 1'b0;
    iss_emit   = 1'b0;
    iss_row    = 2'd0;
    iss_col    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ZTOP;
          x_d        = '0;
          y_d        = '0;
          row_base_d = '0;
          ph_d       = '0;
        end
      end
      S_ZTOP: begin
        dst_we_d   = 1'b1;
        dst_addr_d = row_base_q + x_q;
        x_d        = x_q + 1'b1;
        if (x_q == X_LAST) begin
          x_d        = '0;
          y_d        = ADDR_W'(1);
          row_base_d = W_A;
          ph_d       = '0;
          state_d    = S_PRELOAD;
        end
      end
      S_PRELOAD: begin
        if (ph_q == 3'd0) begin
          dst_we_d   = 1'b1;
          dst_addr_d = row_base_q;
        end
        iss_vld = 1'b1;
        if (ph_q < 3'd3) begin
          iss_row = ph_q[1:0];
          iss_col = '0;
        end else begin
          iss_row = 2'(ph_q - 3'd3);
          iss_col = ADDR_W'(1);
        end
        ph_d = ph_q + 3'd1;
        if (ph_q == 3'd5) begin
          ph_d    = '0;
          x_d     = ADDR_W'(1);
          state_d = S_COLUMN;
        end
      end
      S_COLUMN: begin
        if (ph_q != 3'd3) begin
          iss_vld  = 1'b1;
          iss_row  = ph_q[1:0];
          iss_col  = x_q + 1'b1;
          iss_emit = (ph_q == 3'd2);
        end
        ph_d = ph_q + 3'd1;
        if (ph_q == 3'd3) begin
          ph_d = '0;
          if (x_q == X_INT_LAST) state_d = S_REDGE;
          else                   x_d     = x_q + 1'b1;
        end
      end
      S_REDGE: begin
        // Hold the right-edge write until the last interior result of the row has gone out.
        if (!pipe_busy) begin
          dst_we_d   = 1'b1;
          dst_addr_d = row_base_q + X_LAST;
          row_base_d = row_base_q + W_A;
          x_d        = '0;
          ph_d       = '0;
          if (y_q == Y_INT_LAST) begin
            state_d = S_ZBOT;
          end else begin
            y_d     = y_q + 1'b1;
            state_d = S_PRELOAD;
          end
        end
      end
      S_ZBOT: begin
        dst_we_d   = 1'b1;
        dst_addr_d = row_base_q + x_q;
        x_d        = x_q + 1'b1;
        if (x_q == X_LAST) begin
          x_d     = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (cmp_vld_q) begin
      dst_we_d   = 1'b1;
      dst_addr_d = cmp_addr_q;
      dst_data_d = pix_sat;
    end
  end

  // FSM state, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      ph_q       <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      dst_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      ph_q       <= ph_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      dst_we_q   <= dst_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Read-tag pipeline, column capture and window shift; a completed interior column triggers one compute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_emit_q  <= 1'b0;
      s1_row_q   <= '0;
      s1_waddr_q <= '0;
      s2_vld_q   <= 1'b0;
      s2_emit_q  <= 1'b0;
      s2_row_q   <= '0;
      s2_waddr_q <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      nc_q[0]    <= '0;
      nc_q[1]    <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          p_q[r][c] <= '0;
    end else begin
      s1_vld_q   <= iss_vld;
      s1_emit_q  <= iss_emit;
      s1_row_q   <= iss_row;
      s1_waddr_q <= iss_waddr;
      s2_vld_q   <= s1_vld_q;
      s2_emit_q  <= s1_emit_q;
      s2_row_q   <= s1_row_q;
      s2_waddr_q <= s1_waddr_q;
      cmp_vld_q  <= 1'b0;
      if (s2_vld_q) begin
        if (s2_row_q == 2'd2) begin
          for (int r = 0; r < 3; r++) begin
            p_q[r][0] <= p_q[r][1];
            p_q[r][1] <= p_q[r][2];
          end
          p_q[0][2]  <= nc_q[0];
          p_q[1][2]  <= nc_q[1];
          p_q[2][2]  <= src_data;
          cmp_vld_q  <= s2_emit_q;
          cmp_addr_q <= s2_waddr_q;
        end else begin
          nc_q[s2_row_q[0]] <= src_data;
        end
      end
    end
  end

  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign dst_we   = dst_we_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sobel_engine.sv
// Bench for sobel_engine on an 8x6 image: 1-cycle ROM, RAM/write monitor, arithmetic Sobel reference.
// Scenarios: reset, uniform, vertical step, ramp spacing, random frames, mid-frame reset, start while busy.
// Outputs sampled on the falling edge; inputs driven #1 after the rising edge.
module tb_sobel_engine;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr, dst_addr;
  logic [7:0]    src_data, dst_data;
  logic          dst_we, busy, done;

  int n_chk = 0;
  int n_fail = 0;

  sobel_engine #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .src_data(src_data),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Source image and its 1-cycle-latency ROM
  logic [7:0] img [N];
  always @(posedge clk) src_data <= (src_addr < AW'(N)) ? img[src_addr] : 8'h00;

  // Write monitor / RAM model
  int         cyc = 0;
  int         wcount [N];
  logic [7:0] ram [N];
  int         nwr = 0, nbad = 0, ndone = 0, max_src = 0, done_cyc = -1;
  logic       busy_at_done = 1'b1;
  int         wr_addr_log [$];
  int         wr_cyc_log [$];
  int         clr_gen = 0, clr_seen = 0;

  always @(negedge clk) begin
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      nwr = 0; nbad = 0; ndone = 0; max_src = 0; done_cyc = -1; busy_at_done = 1'b1;
      for (int a = 0; a < N; a++) begin wcount[a] = 0; ram[a] = 8'h00; end
      wr_addr_log.delete();
      wr_cyc_log.delete();
    end
    cyc++;
    if (int'(src_addr) > max_src) max_src = int'(src_addr);
    if (dst_we) begin
      nwr++;
      if (dst_addr < AW'(N)) begin
        wcount[dst_addr]++;
        ram[dst_addr] = dst_data;
      end else nbad++;
      wr_addr_log.push_back(int'(dst_addr));
      wr_cyc_log.push_back(cyc);
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  // Reference: Sobel magnitude straight from the image definition
  function automatic int px(int y, int x);
    return int'(img[y * W + x]);
  endfunction

  function automatic int exp_pix(int a);
    int y, x, gx, gy, m;
    y = a / W;
    x = a % W;
    if (y == 0 || y == H - 1 || x == 0 || x == W - 1) return 0;
    gx = (px(y-1, x+1) + 2 * px(y, x+1) + px(y+1, x+1)) - (px(y-1, x-1) + 2 * px(y, x-1) + px(y+1, x-1));
    gy = (px(y+1, x-1) + 2 * px(y+1, x) + px(y+1, x+1)) - (px(y-1, x-1) + 2 * px(y-1, x) + px(y-1, x+1));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = gx + gy;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic clear_mon();
    clr_gen++;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin timed_out = 1'b0; break; end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (src_addr !== '0) begin n_fail++; $display("FAIL reset src_addr: got %0d want 0", src_addr); end
    n_chk++; if (dst_addr !== '0) begin n_fail++; $display("FAIL reset dst_addr: got %0d want 0", dst_addr); end
    n_chk++; if (dst_data !== '0) begin n_fail++; $display("FAIL reset dst_data: got %0d want 0", dst_data); end
    n_chk++; if (dst_we !== 1'b0) begin n_fail++; $display("FAIL reset dst_we: got %b want 0", dst_we); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_uniform();
    bit to;
    for (int a = 0; a < N; a++) img[a] = 8'd50;
    clear_mon();
    @(posedge clk); #1 start = 1'b1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL uniform busy before start: got %b want 0", busy); end
    @(posedge clk); #1 start = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL uniform busy after start: got %b want 1", busy); end
    wait_done(to);
    n_chk++; if (to) begin n_fail++; $display("FAIL uniform done timeout: no done in 2000 cycles, want one"); end
    for (int a = 0; a < N; a++) begin
      n_chk++;
      if (wcount[a] !== 1 || int'(ram[a]) !== exp_pix(a)) begin
        n_fail++;
        $display("FAIL uniform pix %0d: writes=%0d data=%0d, want writes=1 data=%0d", a, wcount[a], ram[a], exp_pix(a));
      end
    end
    n_chk++; if (nwr !== N || nbad !== 0) begin n_fail++; $display("FAIL uniform write count: got %0d (bad %0d) want %0d", nwr, nbad, N); end
    n_chk++; if (ndone !== 1) begin n_fail++; $display("FAIL uniform done pulses: got %0d want 1", ndone); end
    n_chk++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL uniform busy during done: got %b want 0", busy_at_done); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL uniform busy after frame: got %b want 0", busy); end
    n_chk++;
    if (wr_cyc_log.size() == 0 || done_cyc !== wr_cyc_log[$] + 1) begin
      n_fail++;
      $display("FAIL uniform done timing: done at cycle %0d, last write at %0d, want last+1", done_cyc,
               (wr_cyc_log.size() == 0) ? -1 : wr_cyc_log[$]);
    end
  endtask

  task automatic test_step();
    bit to;
    for (int a = 0; a < N; a++) img[a] = ((a % W) < 4) ? 8'd0 : 8'd200;
    clear_mon();
    pulse_start();
    wait_done(to);
    n_chk++; if (to) begin n_fail++; $display("FAIL step done timeout: no done in 2000 cycles, want one"); end
    for (int a = 0; a < N; a++) begin
      n_chk++;
      if (wcount[a] !== 1 || int'(ram[a]) !== exp_pix(a)) begin
        n_fail++;
        $display("FAIL step pix %0d: writes=%0d data=%0d, want writes=1 data=%0d", a, wcount[a], ram[a], exp_pix(a));
      end
    end
  endtask

  task automatic test_ramp();
    bit to;
    int a, ap, x;
    for (int i = 0; i < N; i++) img[i] = 8'(10 * (i / W));
    clear_mon();
    pulse_start();
    wait_done(to);
    n_chk++; if (to) begin n_fail++; $display("FAIL ramp done timeout: no done in 2000 cycles, want one"); end
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if (wcount[i] !== 1 || int'(ram[i]) !== exp_pix(i)) begin
        n_fail++;
        $display("FAIL ramp pix %0d: writes=%0d data=%0d, want writes=1 data=%0d", i, wcount[i], ram[i], exp_pix(i));
      end
    end
    for (int i = 1; i < wr_addr_log.size(); i++) begin
      a  = wr_addr_log[i];
      ap = wr_addr_log[i-1];
      x  = a % W;
      if (a == ap + 1 && x >= 2 && x <= W - 2 && (a / W) >= 1 && (a / W) <= H - 2) begin
        n_chk++;
        if (wr_cyc_log[i] - wr_cyc_log[i-1] !== 4) begin
          n_fail++;
          $display("FAIL ramp spacing at addr %0d: gap %0d cycles, want 4", a, wr_cyc_log[i] - wr_cyc_log[i-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit to;
    for (int f = 0; f < 3; f++) begin
      for (int a = 0; a < N; a++) img[a] = 8'($urandom_range(0, 255));
      clear_mon();
      pulse_start();
      wait_done(to);
      n_chk++; if (to) begin n_fail++; $display("FAIL random%0d done timeout: no done in 2000 cycles, want one", f); end
      for (int a = 0; a < N; a++) begin
        n_chk++;
        if (wcount[a] !== 1 || int'(ram[a]) !== exp_pix(a)) begin
          n_fail++;
          $display("FAIL random%0d pix %0d: writes=%0d data=%0d, want writes=1 data=%0d", f, a, wcount[a], ram[a], exp_pix(a));
        end
      end
      n_chk++;
      if (wr_addr_log.size() !== N) begin
        n_fail++;
        $display("FAIL random%0d order length: got %0d writes want %0d", f, wr_addr_log.size(), N);
      end else begin
        for (int i = 0; i < N; i++) begin
          n_chk++;
          if (wr_addr_log[i] !== i) begin n_fail++; $display("FAIL random%0d order: write %0d to addr %0d, want %0d", f, i, wr_addr_log[i], i); end
        end
      end
      n_chk++; if (max_src > N - 1) begin n_fail++; $display("FAIL random%0d src range: max src_addr %0d, want <= %0d", f, max_src, N - 1); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int snap;
    for (int a = 0; a < N; a++) img[a] = 8'($urandom_range(0, 255));
    clear_mon();
    pulse_start();
    repeat (99) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({src_addr, dst_addr, dst_data, dst_we, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL midreset outputs: src=%0d dst=%0d data=%0d we=%b busy=%b done=%b, want all 0",
               src_addr, dst_addr, dst_data, dst_we, busy, done);
    end
    snap = nwr;
    n_chk++; if (snap >= N || snap == 0) begin n_fail++; $display("FAIL midreset position: %0d writes before reset, want mid-frame", snap); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_chk++; if (nwr !== snap) begin n_fail++; $display("FAIL midreset writes after reset: got %0d want %0d", nwr, snap); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy after reset: got %b want 0", busy); end
    clear_mon();
    pulse_start();
    wait_done(to);
    n_chk++; if (to) begin n_fail++; $display("FAIL midreset done timeout: no done in 2000 cycles, want one"); end
    for (int a = 0; a < N; a++) begin
      n_chk++;
      if (wcount[a] !== 1 || int'(ram[a]) !== exp_pix(a)) begin
        n_fail++;
        $display("FAIL midreset pix %0d: writes=%0d data=%0d, want writes=1 data=%0d", a, wcount[a], ram[a], exp_pix(a));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int a = 0; a < N; a++) img[a] = 8'($urandom_range(0, 255));
    clear_mon();
    pulse_start();
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (39) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(to);
    n_chk++; if (to) begin n_fail++; $display("FAIL protocol done timeout: no done in 2000 cycles, want one"); end
    repeat (40) @(negedge clk);
    n_chk++; if (ndone !== 1) begin n_fail++; $display("FAIL protocol done pulses: got %0d want 1", ndone); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL protocol restart: busy=%b after frame, want 0", busy); end
    n_chk++; if (nwr !== N || nbad !== 0) begin n_fail++; $display("FAIL protocol write count: got %0d (bad %0d) want %0d", nwr, nbad, N); end
    n_chk++; if (max_src > N - 1) begin n_fail++; $display("FAIL protocol src range: max src_addr %0d, want <= %0d", max_src, N - 1); end
    for (int a = 0; a < N; a++) begin
      n_chk++;
      if (wcount[a] !== 1 || int'(ram[a]) !== exp_pix(a)) begin
        n_fail++;
        $display("FAIL protocol pix %0d: writes=%0d data=%0d, want writes=1 data=%0d", a, wcount[a], ram[a], exp_pix(a));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < N; a++) img[a] = 8'h00;
    test_reset();
    test_uniform();
    test_step();
    test_ramp();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_engine.md
# sobel_engine

Frame-processing stage directly upstream of the VGA display path. On a `start` pulse it walks the static source image in a synchronous ROM once, computes the 3x3 Sobel gradient magnitude for every pixel, and writes one 8-bit result per pixel into the frame-buffer RAM. The VGA side later reads and thresholds that buffer. Output pixels on the image border are written as 0.

## Interface
- `IMG_W`, 256, image width in pixels (≥ 3)
- `IMG_H`, 256, image height in pixels (≥ 3)
- `ADDR_W`, 16, address width; IMG_W*IMG_H ≤ 2^ADDR_W
- `clk`  in  1  system clock, rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle request to process one frame; ignored while `busy`
- `src_addr`  out  ADDR_W  source ROM read address, y*IMG_W + x
- `src_data`  in  8  source ROM data, valid exactly 1 cycle after `src_addr`
- `dst_addr`  out  ADDR_W  frame-buffer write address, y*IMG_W + x
- `dst_data`  out  8  gradient magnitude to write
- `dst_we`  out  1  write strobe, one cycle per output pixel
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after the last write of a frame

## Operation
- All outputs are registered. In reset, every output is 0 and the FSM is in IDLE.
- FSM states:
  - IDLE: waits for `start`, then goes to ZTOP.
  - ZTOP: writes 0 to row 0, x = 0..IMG_W-1, one write per cycle.
  - PRELOAD: for row y (1..IMG_H-2), fetches columns 0 and 1 into the window. During this state it writes 0 at (y,0).
  - COLUMN: for x = 1..IMG_W-2, fetches column x+1, shifts the window left, computes, and writes (y,x).
  - REDGE: writes 0 at (y,IMG_W-1), then goes to PRELOAD for the next row, or to ZBOT after row IMG_H-2.
  - ZBOT: writes 0 to row IMG_H-1.
  - FIN: pulses `done`, then returns to IDLE.
- Column fetch: reads (y-1,c), (y,c), (y+1,c) are issued on 3 consecutive cycles, and each is captured 1 cycle after its issue.
- Window is p[r][c] with r, c in {0,1,2}; r=0 is the row above and c=0 is the left column.
- Gx = (p02 + 2·p12 + p22) − (p00 + 2·p10 + p20), signed 11-bit.
- Gy = (p20 + 2·p21 + p22) − (p00 + 2·p01 + p02), signed 11-bit.
- mag = |Gx| + |Gy|, held in 12 bits. `dst_data` = mag when mag ≤ 255, otherwise 255 (saturates, never wraps).
- Each frame writes every address in 0..IMG_W*IMG_H-1 exactly once, in raster order. No address outside this range is driven with `dst_we` high.
- `src_addr` is always < IMG_W*IMG_H. No reads are issued outside rows 0..IMG_H-1.
- `start` while `busy` is ignored: no restart and no extra `done`.
- Reset mid-frame: outputs clear asynchronously, no further writes occur, and the FSM returns to IDLE. The next `start` processes a full frame.

## Timing
- `busy` rises the cycle after `start` is sampled in IDLE. It falls in the same cycle that `done` is high.
- ZTOP and ZBOT each take IMG_W cycles, with `dst_we` high on every one of those cycles.
- Interior pixel throughput: one column step takes 4 cycles (3 issue cycles + 1 completion cycle). Consecutive interior `dst_we` pulses in a row are exactly 4 cycles apart.
- Latency from the capture of the last pixel of column x+1 to `dst_we` for (y,x) is exactly 1 cycle.
- `dst_addr`, `dst_data` and `dst_we` change together. `dst_addr` and `dst_data` are don't-care when `dst_we` is 0.
- `done` asserts exactly 1 cycle after the final write at (IMG_H-1, IMG_W-1).

## Test plan
All scenarios use IMG_W=8, IMG_H=6 with a behavioural 1-cycle-latency ROM and a RAM model.
- Uniform image, all pixels 50, then `start`:
  - exactly 48 writes, each address 0..47 once, all `dst_data`=0.
  - `done` pulses once and `busy` then drops.
- Vertical step, columns 0–3 = 0 and 4–7 = 200:
  - rows 1–4 at x=3 and x=4 read 255 (Gx=800, saturated).
  - all other pixels read 0.
- Horizontal ramp, src = 10·y:
  - every interior pixel reads 80 (Gy=80, Gx=0).
  - border pixels read 0.
  - interior `dst_we` pulses within a row are 4 cycles apart.
- Reset mid-frame, `rst_n` low for 2 cycles at cycle 100:
  - all outputs read 0 immediately and no writes occur until the next `start`.
  - a following `start` completes all 48 writes correctly.
- Protocol: `start` re-pulsed at cycles 10 and 50 while busy:
  - both are ignored and exactly one `done` pulse occurs.
  - `src_addr` never exceeds 47.
